mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Main control FSM for the multicycle ARM datapath, successor to the fixed-latency controller.
//  Adds variable-latency memory (MemReady wait states with timeout to a sticky FAULT state).
//  Adds a parametrised multi-cycle multiplier path (Op=2'b11): start pulse, busy count, writeback.
//  Sits between the instruction decoder and the datapath; drives all datapath control strobes.
// PARAMETERS
//  MUL_LAT      3   cycles spent in MULEX before MULWB (legal 1..15)
//  MEM_TIMEOUT  15  max wait cycles for MemReady in FETCH/MEMREAD/MEMWRITE; 0 = no timeout (legal 0..255)
// PORTS
//  clk        in   1  clock, rising edge
//  reset      in   1  asynchronous, active-high
//  Op         in   2  instr[27:26]
//  Funct      in   6  instr[25:20]; [5]=I, [0]=L (load)
//  is_long    in   1  long multiply (64-bit result); ignored unless LONG_MUL_EN
//  MemReady   in   1  memory completes access this cycle
//  IRWrite    out  1  latch instruction register
//  AdrSrc     out  1  0=PC, 1=ALU result as memory address
//  ALUSrcA    out  2  ALU A mux select
//  ALUSrcB    out  2  ALU B mux select
//  ResultSrc  out  2  result mux select (11 = multiplier output)
//  NextPC     out  1  PC write enable
//  RegW       out  1  register-file write
//  MemW       out  1  memory write
//  Branch     out  1  branch (PC write if condition passes)
//  ALUOp      out  1  ALU decoder enable
//  MulStart   out  1  one-cycle multiplier start pulse
//  WriteHi    out  1  writeback targets RdHi (long multiply high word)
//  Fault      out  1  sticky memory-timeout indication
//  state_o    out  4  current state encoding (debug)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5 EXECUTER=6 EXECUTEI=7
//   ALUWB=8 BRANCH=9 MULEX=10 MULWB=11 MULWBHI=12 FAULT=13; unused codes -> FETCH next cycle.
//  Reset: state=FETCH, wait/mul counters=0, all outputs 0 except FETCH decode; Fault=0.
//  Transitions: FETCH -> DECODE when MemReady, else hold.
//   DECODE: Op00 -> EXECUTEI if Funct[5] else EXECUTER; Op01 -> MEMADR; Op10 -> BRANCH; Op11 -> MULEX.
//   EXECUTER/EXECUTEI -> ALUWB -> FETCH; MEMADR -> MEMREAD if Funct[0] else MEMWRITE.
//   MEMREAD -> MEMWB on MemReady; MEMWB -> FETCH; MEMWRITE -> FETCH on MemReady; BRANCH -> FETCH.
//   MULEX -> MULWB after exactly MUL_LAT cycles in MULEX; MULWB -> FETCH (or MULWBHI, see config).
//   Any wait state: wait count reaches MEM_TIMEOUT without MemReady -> FAULT; FAULT holds until reset.
//  Outputs {NextPC,Branch,MemW,RegW,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}:
//   FETCH 0000_0_0_10_01_10_0 plus IRWrite=NextPC=1 only in the cycle MemReady=1 (single PC increment).
//   DECODE 0000001001100; MEMADR 0000000000010; MEMREAD 0000010000000; MEMWB 0001000100000.
//   MEMWRITE 0010010000000 (MemW held high throughout wait); EXECUTER ...0001; EXECUTEI ...0011.
//   ALUWB 0001000000000; BRANCH 0100001000010; MULEX 0000000000000.
//   MULWB/MULWBHI 0001001100000; FAULT all zero.
//  MulStart=1 only on first MULEX cycle. WriteHi=1 only in MULWBHI.
//  Wait counter: 8-bit, cleared on entering any wait state and on MemReady; saturates, no wrap.
//  Mul counter: 4-bit, loaded 0 on MULEX entry, increments each MULEX cycle.
//  MemReady outside wait states is ignored. Fault=1 iff state==FAULT.
//  Reset mid-operation (any state, incl. MULEX or wait): immediate return to FETCH, counters cleared.
//  MEM_TIMEOUT and MemReady in the same cycle: MemReady wins (normal transition).
// CONFIGURATION
//  LONG_MUL_EN defined: MULWB -> MULWBHI when is_long sampled 1 in DECODE (registered); MULWBHI -> FETCH.
//  LONG_MUL_EN undefined: MULWBHI unreachable, is_long ignored, WriteHi tied 0.
// TESTING
//  FETCH with MemReady low 2 cycles then high -> IRWrite/NextPC exactly 1 cycle (cycle 3), then DECODE.
//  Op=11, MUL_LAT=3 -> MulStart pulse on cycle 1 of MULEX, MULWB RegW=1 ResultSrc=11 on cycle 4.
//  LDR (Op=01, Funct[0]=1) with MemReady low, MEM_TIMEOUT=15 -> FAULT after 15 wait cycles, Fault=1 until reset.
//  STR with MemReady high on 3rd MEMWRITE cycle -> MemW=1 for 3 cycles, then FETCH.
//  reset asserted during MULEX cycle 2 -> state_o=0 asynchronously, MulStart pulses again on next mul.
//  LONG_MUL_EN, Op=11 is_long=1 -> MULWB then MULWBHI (WriteHi=1, RegW=1), then FETCH.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
//   Main control FSM for the multicycle ARM datapath. It drives every datapath
//   control strobe from the current state. It supports variable-latency memory
//   through MemReady wait states. A wait that runs too long ends in a sticky
//   FAULT state. It also has a multi-cycle multiplier path for Op=2'b11.
//
// Parameters
//   MUL_LAT      cycles spent in MULEX before MULWB (1..15)
//   MEM_TIMEOUT  wait cycles allowed in FETCH/MEMREAD/MEMWRITE before FAULT
//                (0 disables the timeout, legal 0..255)
//
// Optional feature
//   LONG_MUL_EN  when defined, a long multiply (is_long sampled in DECODE)
//                adds a MULWBHI writeback cycle with WriteHi=1. When undefined,
//                MULWBHI is unreachable, is_long is ignored and WriteHi stays 0.
//
// Ports
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   Op, Funct              instr[27:26], instr[25:20] (Funct[5]=I, Funct[0]=L)
//   is_long                long multiply request (LONG_MUL_EN only)
//   MemReady               memory completes the access this cycle
//   IRWrite .. ALUOp       datapath control strobes
//   MulStart               one-cycle multiplier start pulse
//   WriteHi                writeback targets RdHi
//   Fault                  high while in FAULT
//   state_o                current state encoding (debug)
// ---------------------------------------------------------------------------
module mc_ctrl_fsm #(
  parameter int MUL_LAT     = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       is_long,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       MulStart,
  output logic       WriteHi,
  output logic       Fault,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_MULEX    = 4'd10;
  localparam logic [3:0] S_MULWB    = 4'd11;
  localparam logic [3:0] S_MULWBHI  = 4'd12;
  localparam logic [3:0] S_FAULT    = 4'd13;

  // Last value of each counter before it moves on. When the wait counter
  // would reach MEM_TIMEOUT without MemReady, the FSM leaves for FAULT.
  // So a wait state lasts at most MEM_TIMEOUT cycles.
  localparam logic [3:0] MUL_LAST   = 4'(MUL_LAT - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);
  localparam bit         TIMEOUT_EN = (MEM_TIMEOUT != 0);

  logic [3:0]  state, state_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic [3:0]  mul_cnt, mul_cnt_nxt;
  logic        wait_expired;
  logic [12:0] ctrl;

  function automatic logic in_wait(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

  // MemReady takes priority: an access that completes in the timeout
  // cycle still takes the normal transition.
  assign wait_expired = TIMEOUT_EN && (wait_cnt == WAIT_LAST);

`ifdef LONG_MUL_EN
  logic long_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      long_q <= 1'b0;
    else if (state == S_DECODE)
      long_q <= is_long;
  end
`else
  logic unused_is_long;
  assign unused_is_long = is_long;
`endif

  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:
        if (MemReady)          state_nxt = S_DECODE;
        else if (wait_expired) state_nxt = S_FAULT;
        else                   state_nxt = S_FETCH;
      S_DECODE:
        case (Op)
          2'b00:   state_nxt = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_nxt = S_MEMADR;
          2'b10:   state_nxt = S_BRANCH;
          default: state_nxt = S_MULEX;
        endcase
      S_MEMADR:   state_nxt = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:
        if (MemReady)          state_nxt = S_MEMWB;
        else if (wait_expired) state_nxt = S_FAULT;
        else                   state_nxt = S_MEMREAD;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE:
        if (MemReady)          state_nxt = S_FETCH;
        else if (wait_expired) state_nxt = S_FAULT;
        else                   state_nxt = S_MEMWRITE;
      S_EXECUTER: state_nxt = S_ALUWB;
      S_EXECUTEI: state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_MULEX:    state_nxt = (mul_cnt == MUL_LAST) ? S_MULWB : S_MULEX;
`ifdef LONG_MUL_EN
      S_MULWB:    state_nxt = long_q ? S_MULWBHI : S_FETCH;
`else
      S_MULWB:    state_nxt = S_FETCH;
`endif
      S_MULWBHI:  state_nxt = S_FETCH;
      S_FAULT:    state_nxt = S_FAULT;
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (in_wait(state_nxt) && (state_nxt != state))
      wait_cnt_nxt = '0;
    else if (in_wait(state)) begin
      if (MemReady)
        wait_cnt_nxt = '0;
      else if (wait_cnt != 8'hFF)
        wait_cnt_nxt = wait_cnt + 8'd1;
    end

    mul_cnt_nxt = mul_cnt;
    if ((state_nxt == S_MULEX) && (state != S_MULEX))
      mul_cnt_nxt = '0;
    else if (state == S_MULEX)
      mul_cnt_nxt = mul_cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      mul_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mul_cnt  <= mul_cnt_nxt;
    end
  end

  // ctrl = {NextPC,Branch,MemW,RegW,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl = 13'b0_0_0_0_0_0_10_01_10_0;
        // IR latch and PC increment happen only in the cycle the fetch
        // completes, so a stalled fetch advances the PC exactly once.
        if (MemReady) begin
          ctrl[12] = 1'b1;
          ctrl[8]  = 1'b1;
        end
      end
      S_DECODE:             ctrl = 13'b0_0_0_0_0_0_10_01_10_0;
      S_MEMADR:             ctrl = 13'b0_0_0_0_0_0_00_00_01_0;
      S_MEMREAD:            ctrl = 13'b0_0_0_0_0_1_00_00_00_0;
      S_MEMWB:              ctrl = 13'b0_0_0_1_0_0_01_00_00_0;
      S_MEMWRITE:           ctrl = 13'b0_0_1_0_0_1_00_00_00_0;
      S_EXECUTER:           ctrl = 13'b0_0_0_0_0_0_00_00_00_1;
      S_EXECUTEI:           ctrl = 13'b0_0_0_0_0_0_00_00_01_1;
      S_ALUWB:              ctrl = 13'b0_0_0_1_0_0_00_00_00_0;
      S_BRANCH:             ctrl = 13'b0_1_0_0_0_0_10_00_01_0;
      S_MULWB, S_MULWBHI:   ctrl = 13'b0_0_0_1_0_0_11_00_00_0;
      default:              ctrl = '0;
    endcase
  end

  assign {NextPC, Branch, MemW, RegW, IRWrite, AdrSrc,
          ResultSrc, ALUSrcA, ALUSrcB, ALUOp} = ctrl;

  assign MulStart = (state == S_MULEX) && (mul_cnt == 4'd0);
`ifdef LONG_MUL_EN
  assign WriteHi  = (state == S_MULWBHI);
`else
  assign WriteHi  = 1'b0;
`endif
  assign Fault    = (state == S_FAULT);
  assign state_o  = state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_fsm
//   Scenario testbench for mc_ctrl_fsm (MUL_LAT=3, MEM_TIMEOUT=15).
//   Each scenario task queues the expected output vector for every cycle it
//   drives. It pops and compares that vector at the falling edge.
//   Vector = {state_o, ctrl[12:0], MulStart, WriteHi, Fault}.
// ---------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_MULEX    = 4'd10;
  localparam logic [3:0] S_MULWB    = 4'd11;
  localparam logic [3:0] S_MULWBHI  = 4'd12;
  localparam logic [3:0] S_FAULT    = 4'd13;

  // {NextPC,Branch,MemW,RegW,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
  localparam logic [12:0] C_FETCH    = 13'b0000001001100;
  localparam logic [12:0] C_FETCHRDY = 13'b1000101001100;
  localparam logic [12:0] C_DECODE   = 13'b0000001001100;
  localparam logic [12:0] C_MEMADR   = 13'b0000000000010;
  localparam logic [12:0] C_MEMREAD  = 13'b0000010000000;
  localparam logic [12:0] C_MEMWB    = 13'b0001000100000;
  localparam logic [12:0] C_MEMWRITE = 13'b0010010000000;
  localparam logic [12:0] C_EXR      = 13'b0000000000001;
  localparam logic [12:0] C_EXI      = 13'b0000000000011;
  localparam logic [12:0] C_ALUWB    = 13'b0001000000000;
  localparam logic [12:0] C_BRANCH   = 13'b0100001000010;
  localparam logic [12:0] C_MULWB    = 13'b0001001100000;
  localparam logic [12:0] C_ZERO     = 13'b0000000000000;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       is_long;
  logic       MemReady;
  logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp;
  logic       MulStart, WriteHi, Fault;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] state_o;
  logic [19:0] obs;

  int checks = 0;
  int errors = 0;
  logic [19:0] sb_q[$];

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MUL_LAT(3), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .is_long(is_long),
    .MemReady(MemReady), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch),
    .ALUOp(ALUOp), .MulStart(MulStart), .WriteHi(WriteHi), .Fault(Fault),
    .state_o(state_o)
  );

  assign obs = {state_o, NextPC, Branch, MemW, RegW, IRWrite, AdrSrc,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, MulStart, WriteHi, Fault};

  // Row = {MemReady to drive, expected vector}
  function automatic logic [20:0] row(input logic mr, input logic [3:0] st,
                                      input logic [12:0] c, input logic ms,
                                      input logic wh, input logic f);
    return {mr, st, c, ms, wh, f};
  endfunction

  // Leaves the bench at posedge+1 with reset released, DUT in FETCH, counters 0.
  task automatic apply_reset();
    MemReady = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] got, exp;
    reset = 1'b1; MemReady = 1'b0; Op = 2'b00; Funct = '0; is_long = 1'b0;
    #3;
    sb_q.push_back({S_FETCH, C_FETCH, 1'b0, 1'b0, 1'b0});
    got = obs; exp = sb_q.pop_front(); checks++;
    if (got !== exp) begin
      errors++; $display("FAIL reset_async: got %h expected %h", got, exp);
    end
    @(posedge clk); #1;
    sb_q.push_back({S_FETCH, C_FETCH, 1'b0, 1'b0, 1'b0});
    got = obs; exp = sb_q.pop_front(); checks++;
    if (got !== exp) begin
      errors++; $display("FAIL reset_held: got %h expected %h", got, exp);
    end
    reset = 1'b0;
  endtask

  task automatic test_fetch_alu_reg();
    logic [20:0] rows[$];
    logic [19:0] got, exp;
    apply_reset(); Op = 2'b00; Funct = 6'b000000; is_long = 1'b0;
    rows.push_back(row(0, S_FETCH,    C_FETCH,    0, 0, 0));
    rows.push_back(row(0, S_FETCH,    C_FETCH,    0, 0, 0));
    rows.push_back(row(1, S_FETCH,    C_FETCHRDY, 0, 0, 0));
    rows.push_back(row(1, S_DECODE,   C_DECODE,   0, 0, 0));
    rows.push_back(row(0, S_EXECUTER, C_EXR,      0, 0, 0));
    rows.push_back(row(0, S_ALUWB,    C_ALUWB,    0, 0, 0));
    rows.push_back(row(0, S_FETCH,    C_FETCH,    0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      MemReady = rows[i][20]; sb_q.push_back(rows[i][19:0]);
      @(negedge clk);
      got = obs; exp = sb_q.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL fetch_alu_reg cyc %0d: got %h expected %h", i, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_imm_branch();
    logic [20:0] rows[$];
    logic [19:0] got, exp;
    apply_reset(); Op = 2'b00; Funct = 6'b100000; is_long = 1'b0;
    rows.push_back(row(1, S_FETCH,    C_FETCHRDY, 0, 0, 0));
    rows.push_back(row(0, S_DECODE,   C_DECODE,   0, 0, 0));
    rows.push_back(row(0, S_EXECUTEI, C_EXI,      0, 0, 0));
    rows.push_back(row(0, S_ALUWB,    C_ALUWB,    0, 0, 0));
    rows.push_back(row(1, S_FETCH,    C_FETCHRDY, 0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      if (i == 4) Op = 2'b10;
      MemReady = rows[i][20]; sb_q.push_back(rows[i][19:0]);
      @(negedge clk);
      got = obs; exp = sb_q.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL alu_imm cyc %0d: got %h expected %h", i, got, exp);
      end
      @(posedge clk); #1;
    end
    rows.delete();
    rows.push_back(row(1, S_DECODE,   C_DECODE,   0, 0, 0));
    rows.push_back(row(1, S_BRANCH,   C_BRANCH,   0, 0, 0));
    rows.push_back(row(0, S_FETCH,    C_FETCH,    0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      MemReady = rows[i][20]; sb_q.push_back(rows[i][19:0]);
      @(negedge clk);
      got = obs; exp = sb_q.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL branch cyc %0d: got %h expected %h", i, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ldr_str();
    logic [20:0] rows[$];
    logic [19:0] got, exp;
    apply_reset(); Op = 2'b01; Funct = 6'b000001; is_long = 1'b0;
    rows.push_back(row(1, S_FETCH,    C_FETCHRDY, 0, 0, 0));
    rows.push_back(row(1, S_DECODE,   C_DECODE,   0, 0, 0));
    rows.push_back(row(1, S_MEMADR,   C_MEMADR,   0, 0, 0));
    rows.push_back(row(0, S_MEMREAD,  C_MEMREAD,  0, 0, 0));
    rows.push_back(row(1, S_MEMREAD,  C_MEMREAD,  0, 0, 0));
    rows.push_back(row(1, S_MEMWB,    C_MEMWB,    0, 0, 0));
    rows.push_back(row(1, S_FETCH,    C_FETCHRDY, 0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      if (i == 6) Funct = 6'b000000;
      MemReady = rows[i][20]; sb_q.push_back(rows[i][19:0]);
      @(negedge clk);
      got = obs; exp = sb_q.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL ldr cyc %0d: got %h expected %h", i, got, exp);
      end
      @(posedge clk); #1;
    end
    rows.delete();
    rows.push_back(row(0, S_DECODE,   C_DECODE,   0, 0, 0));
    rows.push_back(row(0, S_MEMADR,   C_MEMADR,   0, 0, 0));
    rows.push_back(row(0, S_MEMWRITE, C_MEMWRITE, 0, 0, 0));
    rows.push_back(row(0, S_MEMWRITE, C_MEMWRITE, 0, 0, 0));
    rows.push_back(row(1, S_MEMWRITE, C_MEMWRITE, 0, 0, 0));
    rows.push_back(row(0, S_FETCH,    C_FETCH,    0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      MemReady = rows[i][20]; sb_q.push_back(rows[i][19:0]);
      @(negedge clk);
      got = obs; exp = sb_q.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL str cyc %0d: got %h expected %h", i, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul(input logic lng);
    logic [20:0] rows[$];
    logic [19:0] got, exp;
    apply_reset(); Op = 2'b11; Funct = 6'b000000; is_long = lng;
    rows.push_back(row(1, S_FETCH,    C_FETCHRDY, 0, 0, 0));
    rows.push_back(row(0, S_DECODE,   C_DECODE,   0, 0, 0));
    rows.push_back(row(0, S_MULEX,    C_ZERO,     1, 0, 0));
    rows.push_back(row(1, S_MULEX,    C_ZERO,     0, 0, 0));
    rows.push_back(row(0, S_MULEX,    C_ZERO,     0, 0, 0));
    rows.push_back(row(0, S_MULWB,    C_MULWB,    0, 0, 0));
`ifdef LONG_MUL_EN
    if (lng) rows.push_back(row(0, S_MULWBHI, C_MULWB, 0, 1, 0));
`endif
    rows.push_back(row(0, S_FETCH,    C_FETCH,    0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      MemReady = rows[i][20]; sb_q.push_back(rows[i][19:0]);
      @(negedge clk);
      got = obs; exp = sb_q.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL mul(long=%0d) cyc %0d: got %h expected %h", lng, i, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    logic [20:0] rows[$];
    logic [19:0] got, exp;
    // Load that never completes: 15 MEMREAD cycles, then sticky FAULT.
    apply_reset(); Op = 2'b01; Funct = 6'b000001; is_long = 1'b0;
    rows.push_back(row(1, S_FETCH,  C_FETCHRDY, 0, 0, 0));
    rows.push_back(row(0, S_DECODE, C_DECODE,   0, 0, 0));
    rows.push_back(row(0, S_MEMADR, C_MEMADR,   0, 0, 0));
    for (int k = 0; k < 15; k++) rows.push_back(row(0, S_MEMREAD, C_MEMREAD, 0, 0, 0));
    for (int k = 0; k < 3; k++)  rows.push_back(row(1, S_FAULT, C_ZERO, 0, 0, 1));
    for (int i = 0; i < rows.size(); i++) begin
      MemReady = rows[i][20]; sb_q.push_back(rows[i][19:0]);
      @(negedge clk);
      got = obs; exp = sb_q.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL ldr_timeout cyc %0d: got %h expected %h", i, got, exp);
      end
      @(posedge clk); #1;
    end
    // Ready arriving in the last allowed cycle wins over the timeout.
    apply_reset();
    rows.delete();
    rows.push_back(row(1, S_FETCH,  C_FETCHRDY, 0, 0, 0));
    rows.push_back(row(0, S_DECODE, C_DECODE,   0, 0, 0));
    rows.push_back(row(0, S_MEMADR, C_MEMADR,   0, 0, 0));
    for (int k = 0; k < 14; k++) rows.push_back(row(0, S_MEMREAD, C_MEMREAD, 0, 0, 0));
    rows.push_back(row(1, S_MEMREAD, C_MEMREAD, 0, 0, 0));
    rows.push_back(row(0, S_MEMWB,   C_MEMWB,   0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      MemReady = rows[i][20]; sb_q.push_back(rows[i][19:0]);
      @(negedge clk);
      got = obs; exp = sb_q.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL ready_beats_timeout cyc %0d: got %h expected %h", i, got, exp);
      end
      @(posedge clk); #1;
    end
    // Stalled instruction fetch also times out.
    apply_reset();
    rows.delete();
    for (int k = 0; k < 15; k++) rows.push_back(row(0, S_FETCH, C_FETCH, 0, 0, 0));
    rows.push_back(row(0, S_FAULT, C_ZERO, 0, 0, 1));
    for (int i = 0; i < rows.size(); i++) begin
      MemReady = rows[i][20]; sb_q.push_back(rows[i][19:0]);
      @(negedge clk);
      got = obs; exp = sb_q.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL fetch_timeout cyc %0d: got %h expected %h", i, got, exp);
      end
      @(posedge clk); #1;
    end
    apply_reset();
    sb_q.push_back({S_FETCH, C_FETCH, 1'b0, 1'b0, 1'b0});
    #1 got = obs; exp = sb_q.pop_front(); checks++;
    if (got !== exp) begin
      errors++; $display("FAIL fault_cleared: got %h expected %h", got, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    logic [20:0] rows[$];
    logic [19:0] got, exp;
    apply_reset(); Op = 2'b11; Funct = 6'b000000; is_long = 1'b0;
    rows.push_back(row(1, S_FETCH,  C_FETCHRDY, 0, 0, 0));
    rows.push_back(row(0, S_DECODE, C_DECODE,   0, 0, 0));
    rows.push_back(row(0, S_MULEX,  C_ZERO,     1, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      MemReady = rows[i][20]; sb_q.push_back(rows[i][19:0]);
      @(negedge clk);
      got = obs; exp = sb_q.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL mid_mul_pre cyc %0d: got %h expected %h", i, got, exp);
      end
      @(posedge clk); #1;
    end
    // Now in MULEX cycle 2; reset between clock edges.
    sb_q.push_back({S_MULEX, C_ZERO, 1'b0, 1'b0, 1'b0});
    #1 got = obs; exp = sb_q.pop_front(); checks++;
    if (got !== exp) begin
      errors++; $display("FAIL mulex_cycle2: got %h expected %h", got, exp);
    end
    reset = 1'b1;
    sb_q.push_back({S_FETCH, C_FETCH, 1'b0, 1'b0, 1'b0});
    #1 got = obs; exp = sb_q.pop_front(); checks++;
    if (got !== exp) begin
      errors++; $display("FAIL async_reset_mulex: got %h expected %h", got, exp);
    end
    @(posedge clk); #1 reset = 1'b0;
    rows.delete();
    rows.push_back(row(1, S_FETCH,  C_FETCHRDY, 0, 0, 0));
    rows.push_back(row(0, S_DECODE, C_DECODE,   0, 0, 0));
    rows.push_back(row(0, S_MULEX,  C_ZERO,     1, 0, 0));
    rows.push_back(row(0, S_MULEX,  C_ZERO,     0, 0, 0));
    rows.push_back(row(0, S_MULEX,  C_ZERO,     0, 0, 0));
    rows.push_back(row(0, S_MULWB,  C_MULWB,    0, 0, 0));
    rows.push_back(row(0, S_FETCH,  C_FETCH,    0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      MemReady = rows[i][20]; sb_q.push_back(rows[i][19:0]);
      @(negedge clk);
      got = obs; exp = sb_q.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL mid_mul_rerun cyc %0d: got %h expected %h", i, got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fetch_alu_reg();
    test_alu_imm_branch();
    test_ldr_str();
    test_mul(1'b0);
    test_mul(1'b1);
    test_timeout();
    test_reset_mid_mul();
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
